// File: rtl/systolic_pkg.sv
// Shared types for the systolic array sequencer.
// State encoding, word type and drain-length helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FIN
  } seq_state_e;

  localparam int WORD_W = 16;

  typedef logic signed [WORD_W-1:0] word_t;

  function automatic int drain_cyc(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-depth shift register used to skew one array row.
// DEPTH=0 degenerates to a wire.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk | rst;
      assign q_o = d_i;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] sr_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
        end else begin
          sr_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end

      assign q_o = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_seq.sv
// Weight-load / activation-stream sequencer for the systolic PE array.
// SEQ_WEIGHT_REUSE_EN adds reuse_w to skip weight loading on a job.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
`ifdef SEQ_WEIGHT_REUSE_EN
  input  logic                   reuse_w,
`endif
  input  logic                   w_valid,
  input  logic [COLS*DATA_W-1:0] w_data,
  output logic                   w_ready,
  input  logic                   x_valid,
  input  logic [ROWS*DATA_W-1:0] x_data,
  output logic                   x_ready,
  output logic [COLS-1:0]        pe_accept_w,
  output logic [COLS*DATA_W-1:0] pe_weight,
  output logic [ROWS-1:0]        pe_switch,
  output logic [ROWS-1:0]        pe_valid,
  output logic [ROWS*DATA_W-1:0] pe_input,
  output logic                   busy,
  output logic                   done,
  output logic                   err_underrun
);

  localparam int DRAIN_CYC = drain_cyc(ROWS, COLS);
  localparam int BW        = $clog2(ROWS + 1);
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);
  localparam int LW        = DATA_W + 2;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [DC_W-1:0]  drn_q, drn_d;
  logic             err_q, err_d;

  logic [COLS-1:0]        acc_q;
  logic [COLS*DATA_W-1:0] wgt_q;
  logic [LW-1:0]          lane_q [ROWS];
  logic [LW-1:0]          skew_o [ROWS];

  logic reuse_s;
  logic w_beat;
  logic x_acc;
  logic first_vec;

`ifdef SEQ_WEIGHT_REUSE_EN
  assign reuse_s = reuse_w;
`else
  assign reuse_s = 1'b0;
`endif

  assign w_ready   = (state_q == LOAD_W);
  assign x_ready   = (state_q == STREAM);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err_underrun = err_q;

  assign w_beat    = w_valid & w_ready;
  assign x_acc     = x_valid & x_ready;
  assign first_vec = (vec_q == '0);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    vec_d   = vec_q;
    beat_d  = beat_q;
    drn_d   = drn_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          num_d  = num_vec;
          vec_d  = '0;
          beat_d = '0;
          drn_d  = '0;
          if (!reuse_s)
            state_d = LOAD_W;
          else if (num_vec == '0)
            state_d = FIN;
          else
            state_d = STREAM;
        end
      end
      LOAD_W: begin
        if (w_valid) begin
          if (beat_q == BW'(ROWS - 1))
            state_d = (num_q == '0) ? FIN : STREAM;
          else
            beat_d = beat_q + BW'(1);
        end else if (beat_q != '0) begin
          // a gap inside the burst leaves the array half-loaded
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (x_valid) begin
          vec_d = vec_q + CNT_W'(1);
          if (vec_q + CNT_W'(1) == num_q)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drn_q == DC_W'(DRAIN_CYC - 1))
          state_d = FIN;
        else
          drn_d = drn_q + DC_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      vec_q   <= '0;
      beat_q  <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      wgt_q   <= '0;
      for (int r = 0; r < ROWS; r++)
        lane_q[r] <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      beat_q  <= beat_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
      acc_q   <= w_beat ? '1 : '0;
      wgt_q   <= w_beat ? w_data : '0;
      for (int r = 0; r < ROWS; r++) begin
        lane_q[r] <= {first_vec & x_acc, x_acc,
                      x_acc ? x_data[r*DATA_W +: DATA_W] : DATA_W'(0)};
      end
    end
  end

  assign pe_accept_w = acc_q;
  assign pe_weight   = wgt_q;

  // row r sees its lane r cycles after row 0
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      skew_delay #(
        .DEPTH (r),
        .W     (LW)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .d_i (lane_q[r]),
        .q_o (skew_o[r])
      );
      assign pe_switch[r] = skew_o[r][LW-1];
      assign pe_valid[r]  = skew_o[r][LW-2];
      assign pe_input[r*DATA_W +: DATA_W] = skew_o[r][DATA_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq with per-lane and weight scoreboards.
// Expected beats are queued with their due cycle and popped on arrival.
module tb_systolic_seq;
  import systolic_pkg::*;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int DRAIN = ROWS + COLS - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [CW-1:0]        num_vec;
  logic                 reuse_w;
  logic                 w_valid;
  logic [COLS*DW-1:0]   w_data;
  logic                 w_ready;
  logic                 x_valid;
  logic [ROWS*DW-1:0]   x_data;
  logic                 x_ready;
  logic [COLS-1:0]      pe_accept_w;
  logic [COLS*DW-1:0]   pe_weight;
  logic [ROWS-1:0]      pe_switch;
  logic [ROWS-1:0]      pe_valid;
  logic [ROWS*DW-1:0]   pe_input;
  logic                 busy;
  logic                 done;
  logic                 err_underrun;

  systolic_seq #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vec      (num_vec),
`ifdef SEQ_WEIGHT_REUSE_EN
    .reuse_w      (reuse_w),
`endif
    .w_valid      (w_valid),
    .w_data       (w_data),
    .w_ready      (w_ready),
    .x_valid      (x_valid),
    .x_data       (x_data),
    .x_ready      (x_ready),
    .pe_accept_w  (pe_accept_w),
    .pe_weight    (pe_weight),
    .pe_switch    (pe_switch),
    .pe_valid     (pe_valid),
    .pe_input     (pe_input),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          sw;
    logic [DW-1:0] d;
  } lane_exp_t;

  typedef struct {
    int                 due;
    logic [COLS*DW-1:0] d;
  } w_exp_t;

  lane_exp_t lq [ROWS][$];
  w_exp_t    wq[$];

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int done_due = -1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mon();
    for (int r = 0; r < ROWS; r++) begin
      lane_exp_t e;
      logic      ev;
      ev = (lq[r].size() != 0) && (lq[r][0].due == cyc);
      chk($sformatf("valid%0d@%0d", r, cyc), pe_valid[r], ev);
      if (ev && pe_valid[r]) begin
        e = lq[r].pop_front();
        chk($sformatf("switch%0d@%0d", r, cyc), pe_switch[r], e.sw);
        chk($sformatf("input%0d@%0d", r, cyc),
            pe_input[r*DW +: DW], e.d);
      end else if (!pe_valid[r]) begin
        chk($sformatf("idle_sw%0d@%0d", r, cyc), pe_switch[r], 0);
      end
    end
    begin
      w_exp_t we;
      logic   ea;
      ea = (wq.size() != 0) && (wq[0].due == cyc);
      chk($sformatf("accept_w@%0d", cyc), pe_accept_w,
          ea ? {COLS{1'b1}} : {COLS{1'b0}});
      if (ea) begin
        we = wq.pop_front();
        chk($sformatf("weight@%0d", cyc), pe_weight, we.d);
      end
    end
    chk($sformatf("done@%0d", cyc), done, cyc == done_due);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    mon();
  endtask

  task automatic flush_sb();
    for (int r = 0; r < ROWS; r++) lq[r].delete();
    wq.delete();
    done_due = -1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_underrun, 0);
    chk({tag, "_wrdy"}, w_ready, 0);
    chk({tag, "_xrdy"}, x_ready, 0);
    chk({tag, "_acc"}, pe_accept_w, 0);
    chk({tag, "_wgt"}, pe_weight, 0);
    chk({tag, "_sw"}, pe_switch, 0);
    chk({tag, "_vld"}, pe_valid, 0);
    chk({tag, "_in"}, pe_input, 0);
  endtask

  task automatic go(input logic [CW-1:0] n, input logic reuse);
    start   = 1'b1;
    num_vec = n;
    reuse_w = reuse;
    tick();
    start   = 1'b0;
    reuse_w = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clr", err_underrun, 0);
  endtask

  task automatic beat(input logic [COLS*DW-1:0] w, input logic fin);
    w_valid = 1'b1;
    w_data  = w;
    chk("w_ready", w_ready, 1);
    wq.push_back('{cyc + 1, w});
    if (fin) done_due = cyc + 1;
    tick();
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic vec(input logic [ROWS*DW-1:0] x, input logic first,
                     input logic last);
    x_valid = 1'b1;
    x_data  = x;
    chk("x_ready", x_ready, 1);
    for (int r = 0; r < ROWS; r++)
      lq[r].push_back('{cyc + 1 + r, first, x[r*DW +: DW]});
    if (last) done_due = cyc + 1 + DRAIN;
    tick();
    x_valid = 1'b0;
    x_data  = '0;
  endtask

  task automatic bubble();
    x_valid = 1'b0;
    chk("bubble_xrdy", x_ready, 1);
    tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    start   = 1'b1;
    num_vec = 16'd1;
    tick();
    start   = 1'b0;
    chk("fin_start_ignored", busy, 0);
    done_due = -1;
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("lane%0d_drained", r), lq[r].size(), 0);
    chk("w_drained", wq.size(), 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    reuse_w = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    x_valid = 1'b0;
    x_data  = '0;

    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // 2x2 load then two vectors
    go(16'd2, 1'b0);
    beat({16'h0200, 16'h0100}, 1'b0);
    beat({16'h0400, 16'h0300}, 1'b0);
    vec({16'h0080, 16'h0100}, 1'b1, 1'b0);
    vec({16'h0040, 16'h0200}, 1'b0, 1'b1);
    wait_done();

    // burst gap after first beat
    go(16'd2, 1'b0);
    tick();
    chk("pre_beat_wait_err", err_underrun, 0);
    chk("pre_beat_wait_busy", busy, 1);
    beat({16'h1111, 16'h2222}, 1'b0);
    tick();
    chk("underrun_err", err_underrun, 1);
    chk("underrun_busy", busy, 0);
    tick();
    tick();
    chk("underrun_sticky", err_underrun, 1);

    // bubbles in the stream; start clears the error
    go(16'd3, 1'b0);
    beat({16'hfff0, 16'h0010}, 1'b0);
    beat({16'h0020, 16'hffe0}, 1'b0);
    vec({16'h0a0a, 16'h0101}, 1'b1, 1'b0);
    bubble();
    bubble();
    vec({16'h0b0b, 16'h0202}, 1'b0, 1'b0);
    vec({16'h8000, 16'h7fff}, 1'b0, 1'b1);
    wait_done();

    // zero vectors: done right after loading
    go(16'd0, 1'b0);
    beat({16'h0005, 16'h0006}, 1'b0);
    beat({16'h0007, 16'h0008}, 1'b1);
    wait_done();

    // start while streaming must not relatch num_vec
    go(16'd2, 1'b0);
    beat({16'h0100, 16'h0100}, 1'b0);
    beat({16'h0100, 16'h0100}, 1'b0);
    vec({16'h0003, 16'h0004}, 1'b1, 1'b0);
    start   = 1'b1;
    num_vec = 16'd5;
    vec({16'h0005, 16'h0006}, 1'b0, 1'b1);
    start   = 1'b0;
    chk("busy_start_busy", busy, 1);
    wait_done();

    // reset mid-stream aborts with no done
    go(16'd3, 1'b0);
    beat({16'h0001, 16'h0002}, 1'b0);
    beat({16'h0003, 16'h0004}, 1'b0);
    vec({16'h0055, 16'h0066}, 1'b1, 1'b0);
    rst = 1'b1;
    flush_sb();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet($sformatf("midrst%0d", i));
    end
    rst = 1'b0;
    tick();
    chk_quiet("post_rst");

    go(16'd1, 1'b0);
    beat({16'h0c00, 16'h0d00}, 1'b0);
    beat({16'h0e00, 16'h0f00}, 1'b0);
    vec({16'h1234, 16'h4321}, 1'b1, 1'b1);
    wait_done();

`ifdef SEQ_WEIGHT_REUSE_EN
    go(16'd1, 1'b1);
    chk("reuse_xrdy", x_ready, 1);
    chk("reuse_wrdy", w_ready, 0);
    vec({16'h0099, 16'h0088}, 1'b1, 1'b1);
    wait_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
